// File: rtl/fifo_wr_arbiter.sv
// ============================================================================
// Module      : fifo_wr_arbiter
// Description : Round-robin burst arbiter sharing one FIFO write port among
//               NUM_REQ valid/ready requesters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_wr_arbiter #(
    parameter  int NUM_REQ    = 4,
    parameter  int DATA_WIDTH = 8,
    parameter  int MAX_BURST  = 4,
    localparam int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_wr_data,
    output logic [ID_W-1:0]               grant_id,
    output logic                          busy
);

    localparam int CNT_W = $clog2(MAX_BURST) + 1;

    localparam logic [CNT_W-1:0] c_last_beat = CNT_W'(MAX_BURST - 1);
    localparam logic [ID_W-1:0]  c_rr_reset  = ID_W'(NUM_REQ - 1);
    localparam logic [ID_W:0]    c_num_req   = (ID_W + 1)'(NUM_REQ);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t             r_state;
    logic [ID_W-1:0]    r_grant_id;
    logic [ID_W-1:0]    r_last;
    logic [CNT_W-1:0]   r_beat_cnt;

    logic [DATA_WIDTH-1:0] w_slice [NUM_REQ];
    logic [DATA_WIDTH-1:0] w_cur_data;
    logic                  w_cur_valid;
    logic                  w_beat;
    logic                  w_release;
    logic                  w_found;
    logic [ID_W-1:0]       w_sel;
    logic [ID_W:0]         w_sum;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
            assign w_slice[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // In GRANT r_last always equals r_grant_id, so scanning from r_last+1
    // both serves IDLE arbitration and puts the current owner last on release.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_sum   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_sum = {1'b0, r_last} + (ID_W + 1)'(k);
            if (w_sum >= c_num_req) begin
                w_sum = w_sum - c_num_req;
            end
            if (!w_found && req_valid[w_sum[ID_W-1:0]]) begin
                w_found = 1'b1;
                w_sel   = w_sum[ID_W-1:0];
            end
        end
    end

    assign w_cur_valid  = req_valid[r_grant_id];
    assign w_cur_data   = w_slice[r_grant_id];

    assign busy         = (r_state == S_GRANT);
    assign grant_id     = r_grant_id;
    assign fifo_wr_en   = busy && w_cur_valid && !fifo_full;
    assign fifo_wr_data = fifo_wr_en ? w_cur_data : '0;
    assign req_ready    = (busy && !fifo_full) ? (NUM_REQ'(1) << r_grant_id) : '0;

    // Full cycles are neither beats nor releases, so the burst count freezes.
    assign w_beat       = fifo_wr_en;
    assign w_release    = busy && (!w_cur_valid || (w_beat && (r_beat_cnt == c_last_beat)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_grant_id <= '0;
            r_last     <= c_rr_reset;
            r_beat_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_state    <= S_GRANT;
                        r_grant_id <= w_sel;
                        r_last     <= w_sel;
                        r_beat_cnt <= '0;
                    end
                end
                S_GRANT: begin
                    if (w_release) begin
                        r_beat_cnt <= '0;
                        if (w_found) begin
                            r_grant_id <= w_sel;
                            r_last     <= w_sel;
                        end else begin
                            r_state    <= S_IDLE;
                            r_grant_id <= '0;
                        end
                    end else if (w_beat) begin
                        r_beat_cnt <= r_beat_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
// ============================================================================
// Module      : tb_fifo_wr_arbiter
// Description : Self-checking bench for fifo_wr_arbiter with a queue-based
//               reference model and directed scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MB = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N*DW-1:0] req_data = '0;
    logic            fifo_full = 1'b0;

    logic [N-1:0]    req_ready,    req_ready2;
    logic            fifo_wr_en,   fifo_wr_en2;
    logic [DW-1:0]   fifo_wr_data, fifo_wr_data2;
    logic [1:0]      grant_id,     grant_id2;
    logic            busy,         busy2;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) u_dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en),
        .fifo_wr_data(fifo_wr_data), .grant_id(grant_id), .busy(busy)
    );

    fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready2), .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en2),
        .fifo_wr_data(fifo_wr_data2), .grant_id(grant_id2), .busy(busy2)
    );

    int total = 0;
    int bad   = 0;

    // Pending beats per requester; the queue front is what is presented.
    logic [DW-1:0] q [N][$];

    bit            m_busy;
    int            m_g, m_cnt, m_last;
    logic [N-1:0]  e_ready;
    logic          e_wr_en;
    logic [DW-1:0] e_data;

    function automatic int pick(int base, logic [N-1:0] v);
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (base + k) % N;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i]          = (q[i].size() != 0);
            req_data[i*DW +: DW]  = (q[i].size() != 0) ? q[i][0] : '0;
        end
    endtask

    task automatic model_eval();
        e_ready = '0;
        e_wr_en = 1'b0;
        e_data  = '0;
        if (m_busy && !fifo_full) begin
            e_ready[m_g] = 1'b1;
            if (q[m_g].size() != 0) begin
                e_wr_en = 1'b1;
                e_data  = q[m_g][0];
            end
        end
    endtask

    task automatic model_tick();
        logic [N-1:0] v;
        bit beat, rel;
        int s;
        v = req_valid;
        if (!m_busy) begin
            s = pick(m_last, v);
            if (s >= 0) begin
                m_busy = 1; m_g = s; m_last = s; m_cnt = 0;
            end
        end else begin
            beat = v[m_g] && !fifo_full;
            rel  = !v[m_g] || (beat && (m_cnt + 1 == MB));
            if (beat) void'(q[m_g].pop_front());
            if (rel) begin
                s = pick(m_g, v);
                m_cnt = 0;
                if (s >= 0) begin
                    m_g = s; m_last = s;
                end else begin
                    m_busy = 0;
                end
            end else if (beat) begin
                m_cnt++;
            end
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_g = 0; m_cnt = 0; m_last = N - 1;
    endtask

    task automatic prep();
        drive();
        model_eval();
        #1;
    endtask

    task automatic adv();
        @(posedge clk);
        model_tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        fifo_full = 1'b0;
        for (int i = 0; i < N; i++) q[i].delete();
        drive();
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        rst_n = 1'b0;
        q[0].push_back(8'hAA);
        prep();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0h want 0", busy); end
        total++; if (grant_id !== 2'd0) begin bad++; $display("FAIL reset_grant: got %0h want 0", grant_id); end
        total++; if (req_ready !== 4'b0) begin bad++; $display("FAIL reset_ready: got %0h want 0", req_ready); end
        total++; if (fifo_wr_en !== 1'b0) begin bad++; $display("FAIL reset_wr_en: got %0h want 0", fifo_wr_en); end
        total++; if (fifo_wr_data !== 8'h00) begin bad++; $display("FAIL reset_wr_data: got %0h want 0", fifo_wr_data); end
        q[0].delete();
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        int writes, first_w, last_w;
        do_reset();
        q[0].push_back(8'h11); q[0].push_back(8'h12); q[0].push_back(8'h13);
        writes = 0; first_w = -1; last_w = -1;
        for (int c = 0; c < 6; c++) begin
            prep();
            if (fifo_wr_en === 1'b1) begin
                if (first_w < 0) first_w = c;
                last_w = c;
                total++;
                if (fifo_wr_data !== 8'h11 + 8'(writes) || grant_id !== 2'd0) begin
                    bad++;
                    $display("FAIL single_beat: got data %0h id %0d want data %0h id 0",
                             fifo_wr_data, grant_id, 8'h11 + 8'(writes));
                end
                writes++;
            end
            if (c == 5) begin
                total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_idle: got busy %0h want 0", busy); end
            end
            adv();
        end
        total++; if (writes != 3) begin bad++; $display("FAIL single_count: got %0d want 3", writes); end
        total++;
        if (first_w != 1 || last_w != 3) begin
            bad++; $display("FAIL single_timing: got cycles %0d..%0d want 1..3", first_w, last_w);
        end
    endtask

    task automatic test_round_robin();
        int r;
        logic [7:0] exp_d;
        do_reset();
        for (int i = 0; i < N; i++)
            for (int s = 0; s < 12; s++) q[i].push_back(8'(i * 16 + s));
        prep();
        total++; if (fifo_wr_en !== 1'b0) begin bad++; $display("FAIL rr_arb_cycle: got wr_en %0h want 0", fifo_wr_en); end
        adv();
        for (int k = 0; k < 20; k++) begin
            prep();
            r     = (k / 4) % 4;
            exp_d = 8'(r * 16 + (k / 16) * 4 + k % 4);
            total++;
            if (fifo_wr_en !== 1'b1 || grant_id !== 2'(r) || fifo_wr_data !== exp_d ||
                req_ready !== 4'(1 << r)) begin
                bad++;
                $display("FAIL rr_beat%0d: got en %0h id %0d data %0h rdy %0h want en 1 id %0d data %0h rdy %0h",
                         k, fifo_wr_en, grant_id, fifo_wr_data, req_ready, r, exp_d, 4'(1 << r));
            end
            adv();
        end
    endtask

    task automatic test_full_stall();
        do_reset();
        for (int s = 0; s < 8; s++) begin
            q[2].push_back(8'h20 + 8'(s));
            q[3].push_back(8'h30 + 8'(s));
        end
        for (int c = 0; c <= 10; c++) begin
            fifo_full = (c >= 3 && c <= 7);
            prep();
            if (c >= 3 && c <= 7) begin
                total++;
                if (fifo_wr_en !== 1'b0 || req_ready !== 4'b0 || grant_id !== 2'd2 || busy !== 1'b1) begin
                    bad++;
                    $display("FAIL full_hold_c%0d: got en %0h rdy %0h id %0d busy %0h want 0 0 2 1",
                             c, fifo_wr_en, req_ready, grant_id, busy);
                end
            end else if (c != 0) begin
                total++;
                if (fifo_wr_en !== 1'b1 || grant_id !== e_id(c) || fifo_wr_data !== e_dat(c)) begin
                    bad++;
                    $display("FAIL full_beat_c%0d: got en %0h id %0d data %0h want 1 %0d %0h",
                             c, fifo_wr_en, grant_id, fifo_wr_data, e_id(c), e_dat(c));
                end
            end
            adv();
        end
        fifo_full = 1'b0;
    endtask

    // Cycles 1,2,8,9 write requester 2 (beats 0..3); cycle 10 rotates to 3.
    function automatic logic [1:0] e_id(int c);
        return (c == 10) ? 2'd3 : 2'd2;
    endfunction

    function automatic logic [7:0] e_dat(int c);
        if (c == 10) return 8'h30;
        return (c <= 2) ? 8'h20 + 8'(c - 1) : 8'h22 + 8'(c - 8);
    endfunction

    task automatic test_regrant();
        do_reset();
        for (int s = 0; s < 12; s++) q[1].push_back(8'h40 + 8'(s));
        prep();
        adv();
        for (int k = 0; k < 8; k++) begin
            prep();
            total++;
            if (fifo_wr_en2 !== 1'b1 || grant_id2 !== 2'd1 || fifo_wr_data2 !== 8'h40 + 8'(k) ||
                req_ready2 !== 4'b0010) begin
                bad++;
                $display("FAIL regrant_beat%0d: got en %0h id %0d data %0h rdy %0h want 1 1 %0h 2",
                         k, fifo_wr_en2, grant_id2, fifo_wr_data2, req_ready2, 8'h40 + 8'(k));
            end
            adv();
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int s = 0; s < 6; s++) q[1].push_back(8'h50 + 8'(s));
        prep(); adv();
        prep(); adv();
        rst_n = 1'b0;
        prep();
        total++;
        if (busy !== 1'b0 || fifo_wr_en !== 1'b0 || req_ready !== 4'b0 || fifo_wr_data !== 8'h00 ||
            grant_id !== 2'd0) begin
            bad++;
            $display("FAIL midrst_outputs: got busy %0h en %0h rdy %0h data %0h id %0d want all 0",
                     busy, fifo_wr_en, req_ready, fifo_wr_data, grant_id);
        end
        model_reset();
        q[0].push_back(8'h60);
        drive();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        prep(); adv();
        prep();
        total++;
        if (grant_id !== 2'd0 || fifo_wr_data !== 8'h60 || fifo_wr_en !== 1'b1) begin
            bad++;
            $display("FAIL midrst_priority: got id %0d data %0h en %0h want 0 60 1", grant_id, fifo_wr_data, fifo_wr_en);
        end
        adv();
    endtask

    task automatic test_last_priority();
        do_reset();
        q[1].push_back(8'h71);
        for (int c = 0; c < 3; c++) begin prep(); adv(); end
        q[1].push_back(8'h72);
        q[3].push_back(8'h90);
        prep();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL lastpri_idle: got busy %0h want 0", busy); end
        adv();
        prep();
        total++;
        if (grant_id !== 2'd3 || fifo_wr_data !== 8'h90 || fifo_wr_en !== 1'b1) begin
            bad++; $display("FAIL lastpri_first: got id %0d data %0h en %0h want 3 90 1", grant_id, fifo_wr_data, fifo_wr_en);
        end
        adv();
        prep(); adv();
        prep();
        total++;
        if (grant_id !== 2'd1 || fifo_wr_data !== 8'h72 || fifo_wr_en !== 1'b1) begin
            bad++; $display("FAIL lastpri_second: got id %0d data %0h en %0h want 1 72 1", grant_id, fifo_wr_data, fifo_wr_en);
        end
        adv();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++)
                if (q[i].size() < 3 && $urandom_range(0, 2) == 0) q[i].push_back(8'($urandom));
            fifo_full = ($urandom_range(0, 4) == 0);
            prep();
            total++;
            if ({busy, req_ready, fifo_wr_en, fifo_wr_data} !== {m_busy, e_ready, e_wr_en, e_data}) begin
                bad++;
                $display("FAIL rand_c%0d: got busy %0h rdy %0h en %0h data %0h want %0h %0h %0h %0h",
                         c, busy, req_ready, fifo_wr_en, fifo_wr_data, m_busy, e_ready, e_wr_en, e_data);
            end
            if (m_busy) begin
                total++;
                if (grant_id !== 2'(m_g)) begin
                    bad++; $display("FAIL rand_grant_c%0d: got %0d want %0d", c, grant_id, m_g);
                end
            end
            adv();
        end
        fifo_full = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_full_stall();
        test_regrant();
        test_reset_mid();
        test_last_priority();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
